exp4_unidade_controle: RTL and testbench

EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

---
 rtl/exp4_unidade_controle_pkg.sv | 49 ++++
 rtl/exp4_unidade_controle_edge_detector.sv | 19 +
 rtl/exp4_unidade_controle.sv | 100 ++++++++++
 tb/tb_exp4_unidade_controle.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the exp4 control unit: state codes, output bundle,
// default timeout and the Moore output decode.
package exp4_unidade_controle_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 3000;
    localparam logic [3:0]  DB_INVALIDO     = 4'hF;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_c;
        logic zera_r;
        logic registra_r;
        logic conta_c;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            INICIAL, PREPARACAO: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            REGISTRA:    s.registra_r = 1'b1;
            PROXIMO:     s.conta_c    = 1'b1;
            FIM_ACERTO:  begin s.pronto = 1'b1; s.acertou = 1'b1; end
            FIM_ERRO:    begin s.pronto = 1'b1; s.errou   = 1'b1; end
            FIM_TIMEOUT: begin s.pronto = 1'b1; s.timeout = 1'b1; end
            default:     s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exp4_unidade_controle_edge_detector.sv
// Rising-edge detector: one-cycle pulse when sinal is high and was low at the
// previous clock edge.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic anterior;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) anterior <= 1'b0;
        else        anterior <= sinal;
    end

    assign pulso = sinal & ~anterior;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Control unit for the memory game round: sequences register/compare/advance
// per player move and ends in win, error or timeout.
module exp4_unidade_controle
    import exp4_unidade_controle_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       zeraR,
    output logic       registraR,
    output logic       contaC,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int unsigned    CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LIMITE = CW'(TIMEOUT - 1);

    estado_t       estado;
    estado_t       proximo_estado;
    saidas_t       saidas;
    logic [CW-1:0] conta_tempo;
    logic          pulso_jogada;
    logic          expirou;

    edge_detector u_detector (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (pulso_jogada)
    );

    // A move arriving on the last allowed cycle takes priority over expiry.
    assign expirou = (conta_tempo == LIMITE) && !pulso_jogada;

    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:     proximo_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  proximo_estado = ESPERA;
            ESPERA: begin
                if (pulso_jogada) proximo_estado = REGISTRA;
                else if (expirou) proximo_estado = FIM_TIMEOUT;
                else              proximo_estado = ESPERA;
            end
            REGISTRA:    proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    proximo_estado = FIM_ERRO;
                else if (fimC) proximo_estado = FIM_ACERTO;
                else           proximo_estado = PROXIMO;
            end
            PROXIMO:     proximo_estado = ESPERA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                         proximo_estado = iniciar ? PREPARACAO : estado;
            default:     proximo_estado = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with estado.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= INICIAL;
            saidas      <= decodifica(INICIAL);
            conta_tempo <= '0;
        end else begin
            estado      <= proximo_estado;
            saidas      <= decodifica(proximo_estado);
            conta_tempo <= (estado == ESPERA && proximo_estado == ESPERA)
                           ? conta_tempo + 1'b1 : '0;
        end
    end

    always_comb begin
        db_estado = DB_INVALIDO;
        case (estado)
            INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: db_estado = estado;
            default:                           db_estado = DB_INVALIDO;
        endcase
    end

    assign zeraC     = saidas.zera_c;
    assign zeraR     = saidas.zera_r;
    assign registraR = saidas.registra_r;
    assign contaC    = saidas.conta_c;
    assign pronto    = saidas.pronto;
    assign acertou   = saidas.acertou;
    assign errou     = saidas.errou;
    assign timeout   = saidas.timeout;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Directed bench for exp4_unidade_controle with TIMEOUT=8: expected state and
// outputs are queued per step and compared one cycle later.
module tb_exp4_unidade_controle;
    import exp4_unidade_controle_pkg::*;

    localparam int unsigned TO = 8;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, igual, fimC;
    logic       zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_reg  = 0;
    int unsigned n_conta = 0;

    typedef struct {
        string       tag;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];

    exp4_unidade_controle #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .contaC    (contaC),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Expected outputs, bit order {zeraC,zeraR,registraR,contaC,pronto,acertou,errou,timeout}
    function automatic logic [11:0] modelo(estado_t e);
        logic [7:0] o;
        logic [3:0] c;
        c = e;
        case (e)
            INICIAL, PREPARACAO: o = 8'b1100_0000;
            REGISTRA:            o = 8'b0010_0000;
            PROXIMO:             o = 8'b0001_0000;
            FIM_ACERTO:          o = 8'b0000_1100;
            FIM_ERRO:            o = 8'b0000_1010;
            FIM_TIMEOUT:         o = 8'b0000_1001;
            default:             o = 8'b0000_0000;
        endcase
        return {c, o};
    endfunction

    function automatic logic [11:0] observado();
        return {db_estado, zeraC, zeraR, registraR, contaC, pronto, acertou, errou, timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input string tag, input estado_t e);
        exp_t x;
        sb.push_back('{tag, modelo(e)});
        @(posedge clock);
        #1;
        if (registraR === 1'b1) n_reg++;
        if (contaC === 1'b1) n_conta++;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            chk(x.tag, 32'(observado()), 32'(x.v));
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
        #1 reset = 1'b0;
        #2 chk("reset_state", 32'(observado()), 32'(modelo(INICIAL)));
        #9 reset = 1'b1;

        go("idle", INICIAL);
        iniciar = 1'b1; go("win_prep", PREPARACAO);
        iniciar = 1'b0; go("win_espera", ESPERA);

        // Full win over 16 moves
        n_reg = 0; n_conta = 0;
        for (int i = 0; i < 16; i++) begin
            jogada = 1'b1; go("win_registra", REGISTRA);
            jogada = 1'b0; igual = 1'b1; fimC = (i == 15);
            go("win_comparacao", COMPARACAO);
            if (i == 15) begin
                go("win_fim", FIM_ACERTO);
            end else begin
                go("win_proximo", PROXIMO);
                go("win_espera_loop", ESPERA);
            end
        end
        chk("win_registraR_count", n_reg, 32'd16);
        chk("win_contaC_count", n_conta, 32'd15);
        fimC = 1'b0;
        go("win_hold", FIM_ACERTO);

        // Error on third comparison
        iniciar = 1'b1; go("err_prep", PREPARACAO);
        iniciar = 1'b0; go("err_espera", ESPERA);
        n_conta = 0;
        for (int r = 1; r <= 3; r++) begin
            jogada = 1'b1; go("err_registra", REGISTRA);
            jogada = 1'b0; igual = (r < 3); fimC = 1'b0;
            go("err_comparacao", COMPARACAO);
            if (r < 3) begin
                go("err_proximo", PROXIMO);
                go("err_espera_loop", ESPERA);
            end else begin
                go("err_fim", FIM_ERRO);
            end
        end
        chk("err_contaC_count", n_conta, 32'd2);
        go("err_hold", FIM_ERRO);

        // Restart from fim_erro, then timeout after 8 espera cycles
        iniciar = 1'b1; go("restart_prep", PREPARACAO);
        iniciar = 1'b0; go("restart_espera", ESPERA);
        for (int k = 1; k < TO; k++) go("to_espera", ESPERA);
        go("to_fim", FIM_TIMEOUT);
        go("to_hold", FIM_TIMEOUT);

        // Edge in the last espera cycle wins over expiry
        iniciar = 1'b1; go("late_prep", PREPARACAO);
        iniciar = 1'b0; go("late_espera", ESPERA);
        for (int k = 1; k < TO; k++) go("late_espera_loop", ESPERA);
        jogada = 1'b1; go("late_registra", REGISTRA);
        jogada = 1'b0; igual = 1'b0; go("late_comparacao", COMPARACAO);
        go("late_fim", FIM_ERRO);

        // Jogada already high on entry to espera is not a move
        jogada = 1'b1; go("held_pre", FIM_ERRO);
        n_reg = 0;
        iniciar = 1'b1; go("held_prep", PREPARACAO);
        iniciar = 1'b0; go("held_espera", ESPERA);
        for (int k = 1; k < TO; k++) go("held_espera_loop", ESPERA);
        go("held_timeout", FIM_TIMEOUT);
        chk("held_registraR_count", n_reg, 32'd0);

        // Asynchronous reset while in comparacao
        iniciar = 1'b1; go("ar_prep", PREPARACAO);
        iniciar = 1'b0; jogada = 1'b0; go("ar_espera", ESPERA);
        jogada = 1'b1; go("ar_registra", REGISTRA);
        jogada = 1'b0; igual = 1'b1; fimC = 1'b0; go("ar_comparacao", COMPARACAO);
        #2 reset = 1'b0;
        #1 chk("async_reset_immediate", 32'(observado()), 32'(modelo(INICIAL)));
        @(posedge clock);
        #1 chk("async_reset_held", 32'(observado()), 32'(modelo(INICIAL)));
        #2 reset = 1'b1;
        go("post_reset_idle", INICIAL);
        iniciar = 1'b1; go("post_reset_prep", PREPARACAO);
        iniciar = 1'b0; go("post_reset_espera", ESPERA);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
